md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit owning the HI/LO registers.
- Consumes the E-stage start/operation decode and produces the busy flag that the main controller uses to stall mfhi/mflo/mthi/mtlo and further mult/div in D.
- Models multi-cycle latency with a countdown counter. Operands are sampled on the start cycle; the result commits to HI/LO when the count expires.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is a mult/div-class op this cycle (single-cycle pulse per instruction).
- md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11..15 reserved/no-op.
- src_a  input  32  forwarded rs value from the E-stage mux.
- src_b  input  32  forwarded rt value from the E-stage mux.
- busy  output  1  multi-cycle operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous) clears hi, lo, busy, the counter and the pending result to 0. Reset mid-operation aborts the operation; no partial commit.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter nonzero).
- IDLE with start=1 and md_op in {1,2,3,4,7..10}:
  - Sample src_a/src_b, compute the 64-bit pending result, load the counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - busy rises on the next edge.
- RUN: the counter decrements each edge. On the edge where the counter goes 1->0, commit {hi,lo} <= pending and return to IDLE; busy=0 from that edge. busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- mthi/mtlo with start=1 in IDLE: hi<=src_a or lo<=src_a on the next edge; busy stays 0; no counter activity.
- start while busy=1: ignored entirely, no operand capture and no HI/LO write. The controller guarantees this never occurs; the bench checks the ignore.
- start with md_op 0 or 11..15: no effect.
- hi/lo hold their previous values throughout RUN. The new values are visible only after busy falls.
- mult: signed 32x32 -> 64, hi=upper, lo=lower. multu: unsigned.
- div:
  - Signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend (src_a).
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (src_b=0, div or divu): still busy for DIV_CYCLES; hi/lo left unchanged at commit.
- Simultaneous commit edge and a new start: the start is ignored because busy is still 1 that cycle. The next op may start the cycle after busy falls.

Optional Feature:
- Macro MD_UNIT_MADD_EN.
- Defined: md_op 7..10 are legal.
  - madd: {hi,lo} + signed product.
  - maddu: {hi,lo} + unsigned product.
  - msub: {hi,lo} - signed product.
  - msubu: {hi,lo} - unsigned product.
  - All are mod 2^64 and use MULT_CYCLES latency. The accumulator base is the {hi,lo} value at the start edge.
- Undefined: md_op 7..10 are treated as no-op (same as reserved), and no accumulate adder is synthesized.

Test Plan:
- Reset check: reset=0 mid-run (2 cycles after a div start) -> busy=0, hi=0, lo=0 immediately (asynchronously); after release no commit occurs.
- Signed mult: start, mult, src_a=0xFFFFFFFE (-2), src_b=3 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged while busy.
- Unsigned mult: multu with src_a=0xFFFFFFFF, src_b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- Division cases:
  - div src_a=-7 (0xFFFFFFF9), src_b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 7/0 -> busy 10 cycles, hi/lo unchanged.
- mthi/mtlo and ignored start:
  - mthi src_a=0x12345678 -> hi=0x12345678 next edge, busy never asserted.
  - start/mult pulsed during a div run -> ignored; the div result commits correctly.
- MD_UNIT_MADD_EN: preload hi=0, lo=0xFFFFFFFF via mtlo, then maddu 1x1 -> after 5 cycles hi=1, lo=0. Without the macro the same op leaves hi=0, lo=0xFFFFFFFF and busy=0.

Source files
------------

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage to multiply/divide unit bundle.
// Master (controller side) drives start/md_op/src_a/src_b; slave returns busy/hi/lo.
interface md_unit_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: E-stage mult/div unit owning HI/LO, with countdown-modelled latency.
// Ports: clk, reset (async active-low), md (md_unit_if.slave: start, md_op,
// src_a, src_b in; busy, hi, lo out). Macro MD_UNIT_MADD_EN enables md_op 7..10.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_unit_if.slave    md
);
    localparam logic [3:0] MC4 = 4'(MULT_CYCLES);
    localparam logic [3:0] DC4 = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic        pend_wr;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] a;
    logic [31:0] b;
    assign a = md.src_a;
    assign b = md.src_b;

    logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic op_madd, op_maddu, op_msub, op_msubu;
    assign op_mult  = md.md_op == 4'd1;
    assign op_multu = md.md_op == 4'd2;
    assign op_div   = md.md_op == 4'd3;
    assign op_divu  = md.md_op == 4'd4;
    assign op_mthi  = md.md_op == 4'd5;
    assign op_mtlo  = md.md_op == 4'd6;
`ifdef MD_UNIT_MADD_EN
    assign op_madd  = md.md_op == 4'd7;
    assign op_maddu = md.md_op == 4'd8;
    assign op_msub  = md.md_op == 4'd9;
    assign op_msubu = md.md_op == 4'd10;
`else
    assign op_madd  = 1'b0;
    assign op_maddu = 1'b0;
    assign op_msub  = 1'b0;
    assign op_msubu = 1'b0;
`endif

    // Products: sign-extend to 64 bits so the truncated product is exact.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};

    // One unsigned divider on magnitudes serves both div and divu;
    // signs are restored afterwards (remainder follows the dividend).
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;
    assign neg_a = op_div & a[31];
    assign neg_b = op_div & b[31];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;
    assign uq    = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    assign ur    = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    assign quo   = (neg_a ^ neg_b) ? -uq : uq;
    assign rem   = neg_a ? -ur : ur;

`ifdef MD_UNIT_MADD_EN
    logic [63:0] acc_base;
    assign acc_base = {hi_q, lo_q};
`endif

    logic        go;
    logic        wr;
    logic [3:0]  lat;
    logic [63:0] res;

    always_comb begin
        go  = 1'b0;
        wr  = 1'b1;
        lat = MC4;
        res = '0;
        unique case (1'b1)
            op_mult: begin
                go  = 1'b1;
                res = prod_s;
            end
            op_multu: begin
                go  = 1'b1;
                res = prod_u;
            end
            op_div, op_divu: begin
                go  = 1'b1;
                lat = DC4;
                wr  = b != 32'd0;
                res = {rem, quo};
            end
`ifdef MD_UNIT_MADD_EN
            op_madd: begin
                go  = 1'b1;
                res = acc_base + prod_s;
            end
            op_maddu: begin
                go  = 1'b1;
                res = acc_base + prod_u;
            end
            op_msub: begin
                go  = 1'b1;
                res = acc_base - prod_s;
            end
            op_msubu: begin
                go  = 1'b1;
                res = acc_base - prod_u;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (md.start) begin
                        if (go) begin
                            pend    <= res;
                            pend_wr <= wr;
                            cnt     <= lat;
                            busy_q  <= 1'b1;
                            state   <= RUN;
                        end
                        if (op_mthi) hi_q <= a;
                        if (op_mtlo) lo_q <= a;
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                        if (pend_wr) begin
                            hi_q <= pend[63:32];
                            lo_q <= pend[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, op_madd, op_maddu, op_msub, op_msubu};
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed plus randomized checks of md_unit against an
// arithmetic HI/LO model; prints one CHECKS/ERRORS summary line.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    md_unit_if bus ();

    md_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural model: updates m_hi/m_lo, returns busy length (0 = none).
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     acc = {m_hi, m_lo};
        logic [63:0]     r;
        lat = 0;
        case (op)
            4'd1: begin r = 64'(sa * sb); {m_hi, m_lo} = r; lat = MC; end
            4'd2: begin r = ua * ub; {m_hi, m_lo} = r; lat = MC; end
            4'd3: begin
                lat = DC;
                if (b != 0) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            4'd4: begin
                lat = DC;
                if (b != 0) begin
                    m_lo = 32'(ua / ub);
                    m_hi = 32'(ua % ub);
                end
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MD_UNIT_MADD_EN
            4'd7:  begin {m_hi, m_lo} = acc + 64'(sa * sb); lat = MC; end
            4'd8:  begin {m_hi, m_lo} = acc + ua * ub; lat = MC; end
            4'd9:  begin {m_hi, m_lo} = acc - 64'(sa * sb); lat = MC; end
            4'd10: begin {m_hi, m_lo} = acc - ua * ub; lat = MC; end
`endif
            default: r = acc;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ph = m_hi;
        logic [31:0] pl = m_lo;
        int lat;
        model(op, a, b, lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        for (int i = 0; i < lat; i++) begin
            chk({tag, "/busy"}, {31'b0, bus.busy}, 32'd1);
            chk({tag, "/hold_hi"}, bus.hi, ph);
            chk({tag, "/hold_lo"}, bus.lo, pl);
            @(negedge clk);
        end
        chk({tag, "/idle"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, "/hi"}, bus.hi, m_hi);
        chk({tag, "/lo"}, bus.lo, m_lo);
    endtask

    initial begin
        int lat;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        bus.src_a = '0;
        bus.src_b = '0;

        #2;
        chk("rst/busy", {31'b0, bus.busy}, 32'd0);
        chk("rst/hi", bus.hi, 32'd0);
        chk("rst/lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3);
        chk("mult/hi_k", bus.hi, 32'hFFFFFFFF);
        chk("mult/lo_k", bus.lo, 32'hFFFFFFFA);

        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2);
        chk("multu/hi_k", bus.hi, 32'h00000001);
        chk("multu/lo_k", bus.lo, 32'hFFFFFFFE);

        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2);
        chk("div/hi_k", bus.hi, 32'hFFFFFFFF);
        chk("div/lo_k", bus.lo, 32'hFFFFFFFD);

        run_op("divu0", 4'd4, 32'd7, 32'd0);
        chk("divu0/hi_k", bus.hi, 32'hFFFFFFFF);
        chk("divu0/lo_k", bus.lo, 32'hFFFFFFFD);

        run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf/hi_k", bus.hi, 32'h00000000);
        chk("divovf/lo_k", bus.lo, 32'h80000000);

        run_op("mthi", 4'd5, 32'h12345678, 32'd0);
        chk("mthi/hi_k", bus.hi, 32'h12345678);
        run_op("nop0", 4'd0, 32'hAAAA5555, 32'd1);
        run_op("rsv13", 4'd13, 32'hAAAA5555, 32'd1);

        // Start pulses during a div run (including on the commit edge) are ignored.
        model(4'd4, 32'd100, 32'd7, lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = 4'd4;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(negedge clk);
        for (int i = 0; i < DC; i++) begin
            chk("ign/busy", {31'b0, bus.busy}, 32'd1);
            bus.start = (i == 2) || (i == DC - 1);
            bus.md_op = (i == 2) ? 4'd1 : 4'd5;
            bus.src_a = 32'hDEAD0001;
            bus.src_b = 32'h00000003;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        chk("ign/idle", {31'b0, bus.busy}, 32'd0);
        chk("ign/hi", bus.hi, 32'd2);
        chk("ign/lo", bus.lo, 32'd14);
        @(negedge clk);
        chk("ign/idle2", {31'b0, bus.busy}, 32'd0);
        chk("ign/hi2", bus.hi, m_hi);

        // Accumulate path, or its absence in the default build.
        run_op("mtlo", 4'd6, 32'hFFFFFFFF, 32'd0);
        run_op("mthi0", 4'd5, 32'h00000000, 32'd0);
        run_op("maddu", 4'd8, 32'd1, 32'd1);
`ifdef MD_UNIT_MADD_EN
        chk("maddu/hi_k", bus.hi, 32'd1);
        chk("maddu/lo_k", bus.lo, 32'd0);
`else
        chk("maddu/hi_k", bus.hi, 32'd0);
        chk("maddu/lo_k", bus.lo, 32'hFFFFFFFF);
`endif

        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb & 32'h0000000F;
            run_op("rand", rop, ra, rb);
        end

        // Asynchronous reset two cycles into a div aborts it.
        run_op("pre_hi", 4'd5, 32'hCAFEF00D, 32'd0);
        run_op("pre_lo", 4'd6, 32'h0BADBEEF, 32'd0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = 4'd3;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        @(negedge clk);
        chk("abort/busy_pre", {31'b0, bus.busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort/busy", {31'b0, bus.busy}, 32'd0);
        chk("abort/hi", bus.hi, 32'd0);
        chk("abort/lo", bus.lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (DC + 2) @(negedge clk);
        chk("abort/busy_post", {31'b0, bus.busy}, 32'd0);
        chk("abort/hi_post", bus.hi, m_hi);
        chk("abort/lo_post", bus.lo, m_lo);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
